// File: rtl/fpu_sequencer.sv
// fpu_sequencer: issues one FPU instruction at a time, driving the FPU's
// one-hot select and register addresses for one cycle (or FRC_CYCLES cycles
// for a reciprocal), plus the side signals and completion/exception status.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; every output is 0
// EXEC   | single-cycle operation; done (and possibly illegal) this cycle
// FRC    | reciprocal in progress; select[9] held until counter hits 0
module fpu_sequencer #(
    parameter int FRC_CYCLES = 8
) (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_start,
    input  logic [3:0]  i_opcode,
    input  logic [3:0]  i_a_addr,
    input  logic [3:0]  i_b_addr,
    input  logic [3:0]  i_z_addr,
    input  logic        i_fpu_illegal,
    output logic [11:0] o_select,
    output logic [3:0]  o_rf_a_addr,
    output logic [3:0]  o_rf_b_addr,
    output logic [3:0]  o_rf_z_addr,
    output logic        o_rf_in_fpu,
    output logic        o_alu_mul,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_FRC  = 2'd2;

    localparam logic [3:0] OP_CFR  = 4'h3;
    localparam logic [3:0] OP_CUFR = 4'h5;
    localparam logic [3:0] OP_FMUL = 4'h8;
    localparam logic [3:0] OP_FRC  = 4'h9;

    // Counter counts down to 0 so the last FRC cycle is a terminal-count compare.
    localparam logic [3:0] FRC_LOAD = 4'(FRC_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_opcode;
    logic [3:0]  r_a_addr;
    logic [3:0]  r_b_addr;
    logic [3:0]  r_z_addr;
    logic [3:0]  r_cnt;
    logic        r_pend_illegal;

    logic        w_active;
    logic        w_exec;
    logic        w_frc_last;
    logic [11:0] w_onehot;
    logic        w_sel_any;
    logic        w_is_cast;
    logic        w_to_irf;
    logic        w_uses_mul;

    // State register, instruction capture and reciprocal down-counter.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state        <= S_IDLE;
            r_opcode       <= 4'h0;
            r_a_addr       <= 4'h0;
            r_b_addr       <= 4'h0;
            r_z_addr       <= 4'h0;
            r_cnt          <= 4'h0;
            r_pend_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_opcode       <= i_opcode;
                        r_a_addr       <= i_a_addr;
                        r_b_addr       <= i_b_addr;
                        r_z_addr       <= i_z_addr;
                        r_pend_illegal <= (i_opcode >= 4'hC);
                        if (i_opcode == OP_FRC) begin
                            r_state <= S_FRC;
                            r_cnt   <= FRC_LOAD;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                end
                S_FRC: begin
                    if (r_cnt == 4'h0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'h1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Opcode class decode from the captured opcode.
    always_comb begin
        w_onehot   = 12'h000;
        if (r_opcode < 4'hC) begin
            w_onehot = 12'h001 << r_opcode;
        end
        w_is_cast  = (r_opcode == OP_CFR) || (r_opcode == OP_CUFR);
        w_to_irf   = r_opcode inside {4'h1, 4'h3, 4'h5, 4'hA, 4'hB};
        w_uses_mul = (r_opcode == OP_FMUL) || (r_opcode == OP_FRC);
    end

    // Outputs are decoded from registered state; only illegal sees an input.
    always_comb begin
        w_exec      = (r_state == S_EXEC);
        w_frc_last  = (r_state == S_FRC) && (r_cnt == 4'h0);
        w_active    = w_exec || (r_state == S_FRC);

        o_select    = w_active ? w_onehot : 12'h000;
        w_sel_any   = |o_select;
        o_rf_a_addr = w_active ? r_a_addr : 4'h0;
        o_rf_b_addr = w_active ? r_b_addr : 4'h0;
        o_rf_z_addr = w_active ? r_z_addr : 4'h0;
        o_rf_in_fpu = w_sel_any && w_to_irf;
        o_alu_mul   = w_sel_any && w_uses_mul;
        o_busy      = w_active;
        o_done      = w_exec || w_frc_last;
        o_illegal   = w_exec && (r_pend_illegal || (i_fpu_illegal && w_is_cast));
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer with hand-computed expected output vectors.
// Observed vector layout: {select[11:0], a, b, z, rf_in_fpu, alu_mul, busy, done, illegal}
module tb_fpu_sequencer;

    logic        i_clk = 1'b0;
    logic        i_clr;
    logic        i_start;
    logic [3:0]  i_opcode;
    logic [3:0]  i_a_addr;
    logic [3:0]  i_b_addr;
    logic [3:0]  i_z_addr;
    logic        i_fpu_illegal;
    logic [11:0] o_select;
    logic [3:0]  o_rf_a_addr;
    logic [3:0]  o_rf_b_addr;
    logic [3:0]  o_rf_z_addr;
    logic        o_rf_in_fpu;
    logic        o_alu_mul;
    logic        o_busy;
    logic        o_done;
    logic        o_illegal;

    int vectors = 0;
    int miscompares = 0;

    logic [28:0] obs;
    logic [28:0] exp_v;
    assign obs = {o_select, o_rf_a_addr, o_rf_b_addr, o_rf_z_addr,
                  o_rf_in_fpu, o_alu_mul, o_busy, o_done, o_illegal};

    fpu_sequencer #(.FRC_CYCLES(8)) dut (
        .i_clk         (i_clk),
        .i_clr         (i_clr),
        .i_start       (i_start),
        .i_opcode      (i_opcode),
        .i_a_addr      (i_a_addr),
        .i_b_addr      (i_b_addr),
        .i_z_addr      (i_z_addr),
        .i_fpu_illegal (i_fpu_illegal),
        .o_select      (o_select),
        .o_rf_a_addr   (o_rf_a_addr),
        .o_rf_b_addr   (o_rf_b_addr),
        .o_rf_z_addr   (o_rf_z_addr),
        .o_rf_in_fpu   (o_rf_in_fpu),
        .o_alu_mul     (o_alu_mul),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_illegal     (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] z);
        i_start  = 1'b1;
        i_opcode = op;
        i_a_addr = a;
        i_b_addr = b;
        i_z_addr = z;
    endtask

    task automatic test_reset();
        i_clr = 1'b1;
        issue(4'h6, 4'h1, 4'h2, 4'h3);
        i_fpu_illegal = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (obs !== 29'h0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d: got %h want %h", i, obs, 29'h0);
            end
        end
        i_clr   = 1'b0;
        i_start = 1'b0;
        step();
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL reset_idle: got %h want %h", obs, 29'h0);
        end
    endtask

    task automatic test_fadd();
        issue(4'h6, 4'h1, 4'h3, 4'h4);
        step();
        i_start = 1'b0;
        exp_v = {12'h040, 4'h1, 4'h3, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL fadd_exec: got %h want %h", obs, exp_v);
        end
        step();
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL fadd_idle: got %h want %h", obs, 29'h0);
        end
    endtask

    task automatic test_frc();
        issue(4'h9, 4'h2, 4'h7, 4'h5);
        step();
        i_start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            exp_v = {12'h200, 4'h2, 4'h7, 4'h5, 1'b0, 1'b1, 1'b1, (i == 8), 1'b0};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL frc_cycle%0d: got %h want %h", i, obs, exp_v);
            end
            // A second instruction offered during cycles 2..8 must be ignored.
            if (i >= 2) begin
                issue(4'h6, 4'h9, 4'h9, 4'h9);
            end
            step();
        end
        i_start = 1'b0;
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL frc_after: got %h want %h", obs, 29'h0);
        end
        step();
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL frc_ignored_start: got %h want %h", obs, 29'h0);
        end
    endtask

    task automatic test_cast_and_writeback();
        // cfr with the FPU flagging out-of-range
        i_fpu_illegal = 1'b1;
        issue(4'h3, 4'h6, 4'h0, 4'h8);
        step();
        i_start = 1'b0;
        exp_v = {12'h008, 4'h6, 4'h0, 4'h8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL cfr_fault: got %h want %h", obs, exp_v);
        end
        step();
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL cfr_idle_flag_ignored: got %h want %h", obs, 29'h0);
        end
        // feq ignores fpu_illegal but writes the integer register file
        issue(4'hB, 4'hA, 4'hB, 4'hC);
        step();
        i_start = 1'b0;
        exp_v = {12'h800, 4'hA, 4'hB, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL feq_writeback: got %h want %h", obs, exp_v);
        end
        step();
        // fmul borrows the ALU multiplier; flag still ignored
        issue(4'h8, 4'h1, 4'h2, 4'h3);
        step();
        i_start = 1'b0;
        exp_v = {12'h100, 4'h1, 4'h2, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL fmul_mul: got %h want %h", obs, exp_v);
        end
        step();
        // cufr without a fault
        i_fpu_illegal = 1'b0;
        issue(4'h5, 4'hF, 4'h0, 4'h1);
        step();
        i_start = 1'b0;
        exp_v = {12'h020, 4'hF, 4'h0, 4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL cufr_clean: got %h want %h", obs, exp_v);
        end
        // same EXEC cycle, flag rising combinationally
        i_fpu_illegal = 1'b1;
        #1;
        exp_v = {12'h020, 4'hF, 4'h0, 4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL cufr_fault: got %h want %h", obs, exp_v);
        end
        i_fpu_illegal = 1'b0;
        step();
    endtask

    task automatic test_undefined();
        issue(4'hE, 4'h4, 4'h5, 4'h6);
        step();
        i_start = 1'b0;
        exp_v = {12'h000, 4'h4, 4'h5, 4'h6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL undef_opcode: got %h want %h", obs, exp_v);
        end
        step();
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL undef_idle: got %h want %h", obs, 29'h0);
        end
    endtask

    task automatic test_back_to_back();
        // start held high: fsub is only accepted two cycles after fadd
        issue(4'h6, 4'h1, 4'h1, 4'h1);
        step();
        issue(4'h7, 4'h2, 4'h2, 4'h2);
        exp_v = {12'h040, 4'h1, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL b2b_first: got %h want %h", obs, exp_v);
        end
        step();
        vectors++;
        if (obs !== 29'h0) begin
            miscompares++;
            $display("FAIL b2b_gap: got %h want %h", obs, 29'h0);
        end
        step();
        i_start = 1'b0;
        exp_v = {12'h080, 4'h2, 4'h2, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL b2b_second: got %h want %h", obs, exp_v);
        end
        step();
    endtask

    task automatic test_abort();
        issue(4'h9, 4'h3, 4'h4, 4'h5);
        step();
        i_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_v = {12'h200, 4'h3, 4'h4, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL abort_frc_cycle%0d: got %h want %h", i, obs, exp_v);
            end
            if (i < 4) step();
        end
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (obs !== 29'h0) begin
                miscompares++;
                $display("FAIL abort_zero%0d: got %h want %h", i, obs, 29'h0);
            end
            step();
        end
        issue(4'h0, 4'h1, 4'h2, 4'h3);
        step();
        i_start = 1'b0;
        exp_v = {12'h001, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL abort_mvrf: got %h want %h", obs, exp_v);
        end
        step();
    endtask

    initial begin
        i_clr         = 1'b1;
        i_start       = 1'b0;
        i_opcode      = 4'h0;
        i_a_addr      = 4'h0;
        i_b_addr      = 4'h0;
        i_z_addr      = 4'h0;
        i_fpu_illegal = 1'b0;
        #2;
        test_reset();
        test_fadd();
        test_frc();
        test_cast_and_writeback();
        test_undefined();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
